// File: rtl/num_feeder.sv
// Symbol queue feeding a downstream sequence detector: zero symbols are filtered, one symbol is popped per cycle unless held.
// Optional macro NUM_FEEDER_COUNT_EN adds a saturating 8-bit sent_cnt output counting pops.
module num_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    in_num,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          hold,
    output logic [1:0]    num,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
`ifdef NUM_FEEDER_COUNT_EN
    ,
    output logic [7:0]    sent_cnt
`endif
);

    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    num_q, num_d;
    logic          push;
    logic          pop;

    // Full/empty come from the occupancy count so pointer equality is never ambiguous.
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == DEPTH[AW:0]);
    assign level    = cnt_q;
    assign num      = num_q;
    assign in_ready = !full && !reset;

    assign push = in_valid && in_ready && (in_num != 2'd0);
    assign pop  = !hold && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        num_d    = 2'd0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            num_d    = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            num_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
        end
    end

    // Storage is left unreset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_num;
        end
    end

`ifdef NUM_FEEDER_COUNT_EN
    logic [7:0] sent_q, sent_d;

    always_comb begin
        sent_d = sent_q;
        if (pop && (sent_q != 8'hFF)) begin
            sent_d = sent_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_q <= 8'd0;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign sent_cnt = sent_q;
`endif

endmodule
